// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the dmem_lsu load/store unit.
package dmem_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned size codes exist only for loads.
   function automatic logic funct3_illegal(input logic is_write, input logic [2:0] f3);
      logic bad;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = is_write;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational load lane extraction/extension and sub-word store merge.
module lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Halfwords are selected by lane bit 1 only, so an odd address never straddles lanes.
   always_comb begin
      byte_s = rdata_i[{lane_i, 3'b000} +: 8];
      half_s = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
         F3_BU:   load_data_o = {24'd0, byte_s};
         F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
         F3_HU:   load_data_o = {16'd0, half_s};
         default: load_data_o = rdata_i;
      endcase
   end

   // Overwrite only the addressed lane of the word just read.
   always_comb begin
      merged_o = rdata_i;
      case (funct3_i)
         F3_B: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         F3_H: begin
            if (lane_i[1]) begin
               merged_o[31:16] = wdata_i[15:0];
            end else begin
               merged_o[15:0] = wdata_i[15:0];
            end
         end
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between execute stage and word-addressed data memory.
// Optional alignment checking is enabled by defining DMEM_LSU_MISALIGN_CHECK_EN.
module dmem_lsu
   import dmem_lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [9:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [9:0]  mem_byte_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   lsu_state_e  state_q, state_d;
   logic [9:0]  addr_q, addr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_data_q, resp_data_d;
   logic        accept_s, reject_s, misalign_s;
   logic [31:0] load_data_s, merged_s;

`ifdef DMEM_LSU_MISALIGN_CHECK_EN
   always_comb begin
      case (req_funct3)
         F3_H, F3_HU: misalign_s = req_addr[0];
         F3_W:        misalign_s = |req_addr[1:0];
         default:     misalign_s = 1'b0;
      endcase
   end
`else
   assign misalign_s = 1'b0;
`endif

   assign accept_s = req_valid && (state_q == IDLE);
   assign reject_s = funct3_illegal(req_write, req_funct3) || misalign_s;

   lsu_align u_align (
      .rdata_i     (mem_read_data),
      .lane_i      (addr_q[1:0]),
      .funct3_i    (funct3_q),
      .wdata_i     (wdata_q),
      .load_data_o (load_data_s),
      .merged_o    (merged_s)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s && !reject_s) begin
               state_d = ACCESS;
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            if (write_q && (funct3_q != F3_W)) begin
               state_d = WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory strobe is computed a cycle early so it is a clean register during ACCESS/WRITE.
   always_comb begin
      addr_d       = addr_q;
      funct3_d     = funct3_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_data_d  = 32'd0;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               addr_d   = req_addr;
               funct3_d = req_funct3;
               write_d  = req_write;
               wdata_d  = req_wdata;
               if (reject_s) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write && (req_funct3 == F3_W)) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = req_wdata;
               end else begin
                  mem_we_d = 1'b0;
               end
            end else begin
               mem_we_d = 1'b0;
            end
         end
         ACCESS: begin
            if (!write_q) begin
               resp_valid_d = 1'b1;
               resp_data_d  = load_data_s;
            end else if (funct3_q == F3_W) begin
               resp_valid_d = 1'b1;
            end else begin
               mem_we_d    = 1'b1;
               mem_wdata_d = merged_s;
            end
         end
         WRITE:   resp_valid_d = 1'b1;
         default: resp_valid_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q       <= 10'd0;
         funct3_q     <= 3'd0;
         write_q      <= 1'b0;
         wdata_q      <= 32'd0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_data_q  <= 32'd0;
      end else begin
         addr_q       <= addr_d;
         funct3_q     <= funct3_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_data_q  <= resp_data_d;
      end
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = resp_valid_q;
   assign resp_err         = resp_err_q;
   assign resp_data        = resp_data_q;
   assign mem_byte_address = {addr_q[9:2], 2'b00};
   assign mem_write_enable = mem_we_q;
   assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed table, multi-cycle corner cases, random ops.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [9:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_err;
   logic [9:0]  mem_byte_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] ram     [0:255] = '{default: 32'd0};
   logic [31:0] ref_mem [0:255] = '{default: 32'd0};
   int n_writes = 0;
   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_word;
   } vec_t;

   vec_t vecs [14];

   dmem_lsu dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_data        (resp_data),
      .resp_err         (resp_err),
      .mem_byte_address (mem_byte_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write captured at the rising edge.
   assign mem_read_data = ram[mem_byte_address[9:2]];
   always @(posedge clk) begin
      if (mem_write_enable) begin
         ram[mem_byte_address[9:2]] <= mem_write_data;
         n_writes <= n_writes + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: expected response from the size/sign rules, updating ref_mem.
   task automatic ref_op(input logic w, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e,
                         output int lat, output int nwr);
      int ai, wi, bsh, hsh;
      logic [31:0] word, b, h;
      logic bad;
      ai   = int'(a);
      wi   = ai / 4;
      bsh  = 8 * (ai % 4);
      hsh  = 16 * ((ai / 2) % 2);
      word = ref_mem[wi];
      bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (w && (f3 >= 3'd4));
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
      if (((f3 == 3'd1) || (f3 == 3'd5)) && (ai % 2 != 0)) bad = 1'b1;
      if ((f3 == 3'd2) && (ai % 4 != 0)) bad = 1'b1;
`endif
      d = 32'd0; e = 1'b0; lat = 2; nwr = 0;
      b = (word >> bsh) & 32'hFF;
      h = (word >> hsh) & 32'hFFFF;
      if (bad) begin
         e = 1'b1;
         lat = 1;
      end else if (!w) begin
         case (f3)
            3'd0:    d = (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd4:    d = b;
            3'd1:    d = (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    d = h;
            default: d = word;
         endcase
      end else begin
         nwr = 1;
         if (f3 == 3'd2) begin
            ref_mem[wi] = wd;
         end else if (f3 == 3'd0) begin
            lat = 3;
            ref_mem[wi] = (word & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
         end else begin
            lat = 3;
            ref_mem[wi] = (word & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
         end
      end
   endtask

   task automatic run_op(input logic w, input logic [2:0] f3, input logic [9:0] a,
                         input logic [31:0] wd, output logic [31:0] d, output logic e,
                         output int lat);
      @(negedge clk);
      check("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; d = 32'd0; e = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = i; d = resp_data; e = resp_err;
            break;
         end
      end
      if (lat == 0) begin
         n_checks++; n_fail++;
         $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, md;
      logic e, me;
      int lat, mlat, mwr, wr0;
      logic w;
      logic [2:0] f3;
      logic [9:0] a;
      logic [31:0] wd;

      vecs[0]  = '{1'b1, 3'b010, 10'h008, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF};
      vecs[1]  = '{1'b1, 3'b010, 10'h004, 32'h0BADF00D, 32'h0, 1'b0, 2, 32'h0BADF00D};
      vecs[2]  = '{1'b0, 3'b010, 10'h008, 32'h0, 32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
      vecs[3]  = '{1'b0, 3'b000, 10'h00B, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 32'hDEADBEEF};
      vecs[4]  = '{1'b0, 3'b100, 10'h00B, 32'h0, 32'h000000DE, 1'b0, 2, 32'hDEADBEEF};
      vecs[5]  = '{1'b0, 3'b001, 10'h008, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 32'hDEADBEEF};
      vecs[6]  = '{1'b0, 3'b101, 10'h00A, 32'h0, 32'h0000DEAD, 1'b0, 2, 32'hDEADBEEF};
      vecs[7]  = '{1'b1, 3'b000, 10'h009, 32'h00000012, 32'h0, 1'b0, 3, 32'hDEAD12EF};
      vecs[8]  = '{1'b1, 3'b001, 10'h00A, 32'h00005678, 32'h0, 1'b0, 3, 32'h567812EF};
      vecs[9]  = '{1'b0, 3'b011, 10'h008, 32'h0, 32'h0, 1'b1, 1, 32'h567812EF};
      vecs[10] = '{1'b1, 3'b100, 10'h008, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 32'h567812EF};
      vecs[11] = '{1'b0, 3'b000, 10'h00A, 32'h0, 32'h00000078, 1'b0, 2, 32'h567812EF};
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
      vecs[12] = '{1'b0, 3'b010, 10'h006, 32'h0, 32'h0, 1'b1, 1, 32'h0BADF00D};
      vecs[13] = '{1'b0, 3'b101, 10'h009, 32'h0, 32'h0, 1'b1, 1, 32'h567812EF};
`else
      vecs[12] = '{1'b0, 3'b010, 10'h006, 32'h0, 32'h0BADF00D, 1'b0, 2, 32'h0BADF00D};
      vecs[13] = '{1'b0, 3'b101, 10'h009, 32'h0, 32'h000012EF, 1'b0, 2, 32'h567812EF};
`endif

      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_funct3 = 3'd0; req_addr = 10'd0; req_wdata = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_data", resp_data, 32'd0);
      check("rst_resp_err", {31'd0, resp_err}, 32'd0);
      check("rst_mem_addr", {22'd0, mem_byte_address}, 32'd0);
      check("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) begin
         ref_op(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, md, me, mlat, mwr);
         wr0 = n_writes;
         run_op(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, d, e, lat);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_ram", i), ram[vecs[i].addr[9:2]], vecs[i].exp_word);
         check($sformatf("vec%0d_writes", i), n_writes - wr0, (vecs[i].w && !vecs[i].exp_err) ? 1 : 0);
      end

      // Reset asserted while an SB sits in WRITE: the merged write must be dropped.
      wr0 = n_writes;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 10'h00D; req_wdata = 32'hAA;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rmw_we_in_write", {31'd0, mem_write_enable}, 32'd1);
      reset_n = 1'b0;
      #1;
      check("rstw_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rstw_resp_data", resp_data, 32'd0);
      check("rstw_resp_err", {31'd0, resp_err}, 32'd0);
      check("rstw_mem_addr", {22'd0, mem_byte_address}, 32'd0);
      check("rstw_mem_we", {31'd0, mem_write_enable}, 32'd0);
      @(negedge clk);
      check("rstw_ram", ram[3], ref_mem[3]);
      check("rstw_writes", n_writes - wr0, 0);
      reset_n = 1'b1;
      #1;
      check("rstw_req_ready", {31'd0, req_ready}, 32'd1);

      // Back-to-back: second LW accepted in the cycle the first response is valid.
      ref_op(1'b0, 3'b010, 10'h008, 32'd0, md, me, mlat, mwr);
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 10'h008;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("b2b_first_valid", {31'd0, resp_valid}, 32'd1);
      check("b2b_ready_with_valid", {31'd0, req_ready}, 32'd1);
      check("b2b_first_data", resp_data, md);
      ref_op(1'b0, 3'b010, 10'h004, 32'd0, md, me, mlat, mwr);
      req_valid = 1'b1; req_addr = 10'h004;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = i;
            break;
         end
      end
      check("b2b_second_lat", lat, 2);
      check("b2b_second_data", resp_data, md);

      for (int i = 0; i < 150; i++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = 10'($urandom_range(0, 63));
         wd = $urandom;
         ref_op(w, f3, a, wd, md, me, mlat, mwr);
         wr0 = n_writes;
         run_op(w, f3, a, wd, d, e, lat);
         check($sformatf("rnd%0d_data", i), d, md);
         check($sformatf("rnd%0d_err", i), {31'd0, e}, {31'd0, me});
         check($sformatf("rnd%0d_lat", i), lat, mlat);
         check($sformatf("rnd%0d_ram", i), ram[a[9:2]], ref_mem[a[9:2]]);
         check($sformatf("rnd%0d_writes", i), n_writes - wr0, mwr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting between the CPU execute stage and the word-addressed data memory. Accepts one byte/halfword/word load or store per request, formats load data (sign/zero extension), performs read-modify-write for sub-word stores, and returns a single-cycle response. Drives the memory's byte address, write enable and write data. Reads the memory's combinational read data.

## Interface
- No parameters; widths fixed by memory: 10-bit byte address, 32-bit data.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores.
- req_addr  in  10  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_data  out  32  formatted load data; 0 for stores and errors.
- resp_err  out  1  request rejected (misaligned/illegal), valid with resp_valid.
- mem_byte_address  out  10  to memory; low 2 bits always 0.
- mem_write_enable  out  1  to memory; registered at memory's clock edge.
- mem_write_data  out  32  to memory.
- mem_read_data  in  32  from memory, combinational on mem_byte_address.

## Operation
- States: IDLE, ACCESS, WRITE.
- IDLE: req_ready=1. On req_valid: latch addr, funct3, write, wdata; → ACCESS (or error path, see Configuration).
- ACCESS, load: extract byte/half from mem_read_data by addr[1:0] (half by addr[1]); sign-extend for B/H, zero-extend for BU/HU; register into resp_data; resp_valid next cycle; → IDLE.
- ACCESS, SW: mem_write_enable=1, mem_write_data=wdata; resp_valid next cycle; → IDLE.
- ACCESS, SB/SH: merge wdata low byte/half into mem_read_data at the lane selected by addr[1:0]; register merged word; → WRITE.
- WRITE: mem_write_enable=1, mem_write_data=merged word; resp_valid next cycle; → IDLE.
- mem_write_enable is high only in ACCESS (SW) and WRITE; never in IDLE.
- mem_byte_address = {latched addr[9:2], 2'b00}.
- Illegal funct3 (011, 110, 111; or 1xx on store): error response, no memory access.
- Reset (any state, any time): state IDLE, resp_valid 0, resp_data 0, resp_err 0, latched addr 0 (so mem_byte_address 0), mem_write_enable 0. A pending RMW write is dropped; a write already captured by the memory edge stands.

## Timing
- Request accepted at edge E0 (req_valid & req_ready).
- Load, SW: resp_valid high in cycle after E1 (2-cycle latency); memory write of SW occurs at E1.
- SB/SH: read in cycle E0–E1, write at E2, resp_valid after E2 (3-cycle latency).
- Error: resp_valid, resp_err=1 in cycle after E0 (1-cycle latency), state stays IDLE.
- resp_valid and req_ready may be high together; a new request accepted in that cycle is legal (back-to-back).
- req_valid while req_ready=0 is ignored; requester holds it.

## Configuration
- DMEM_LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]≠0 → error response, no memory access.
- Undefined: no alignment check; H uses addr[1] only, W ignores addr[1:0]; access performed normally. Illegal funct3 still errors.

## Structure
- dmem_lsu_pkg: state enum (IDLE/ACCESS/WRITE), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module lsu_align: combinational load extraction/extension and store lane merge; FSM and registers stay in dmem_lsu.

## Test plan
- SW addr 0x008 data 0xDEADBEEF → ram[2]=0xDEADBEEF at E1, resp_valid after 2 cycles, resp_err 0; LW addr 0x008 → resp_data 0xDEADBEEF.
- ram[2]=0xDEADBEEF; LB addr 0x00B → 0xFFFFFFDE; LBU addr 0x00B → 0x000000DE; LH 0x008 → 0xFFFFBEEF; LHU 0x00A → 0x0000DEAD.
- ram[2]=0xDEADBEEF; SB addr 0x009 data 0x12 → ram[2]=0xDEAD12EF after 3 cycles; SH addr 0x00A data 0x5678 → 0x567812EF.
- With macro: LW addr 0x006 → resp_err 1 after 1 cycle, mem_write_enable never asserted; without macro: same request reads ram[1].
- Assert reset_n low during WRITE of SB → no write issued, all outputs 0 while low, req_ready 1 after release.
- Back-to-back: LW accepted in same cycle as previous resp_valid → second resp_valid exactly 2 cycles later.
